polyphase_fir_interp: RTL and testbench

Polyphase FIR interpolator with an integrated phase counter. It takes signed fixed-point symbols at rate clk/N_OS and produces one filtered output per clock, which upsamples by N_OS. Typical use is as a transmit pulse-shaping filter in the communications channel chain, between the symbol source and the channel model. Coefficients are supplied externally as a flat bus.

---
 rtl/polyphase_fir_interp.sv | 100 ++++++++++
 tb/tb_polyphase_fir_interp.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/polyphase_fir_interp.sv
// Polyphase FIR interpolator: one symbol enters every N_OS enabled clocks and one
// filtered sample leaves every enabled clock, using coefficient phase p of h.
module polyphase_fir_interp #(
  parameter int NB_INPUT   = 8,
  parameter int NBF_INPUT  = 7,
  parameter int NB_OUTPUT  = 8,
  parameter int NBF_OUTPUT = 7,
  parameter int NB_COEFF   = 8,
  parameter int NBF_COEFF  = 7,
  parameter int N_BAUD     = 6,
  parameter int N_OS       = 4,
  parameter int NB_PHASE   = 2
) (
  input  logic                                clk,
  input  logic                                i_srst,
  input  logic                                i_en,
  input  logic signed [NB_INPUT-1:0]          i_is_data,
  input  logic [N_BAUD*N_OS*NB_COEFF-1:0]     i_coeff,
  output logic signed [NB_OUTPUT-1:0]         o_os_data,
  output logic [NB_PHASE-1:0]                 o_phase
);

  localparam int NB_PROD = NB_INPUT + NB_COEFF;
  localparam int GUARD   = (N_BAUD > 1) ? $clog2(N_BAUD) : 1;
  localparam int NB_ACC  = NB_PROD + GUARD;
  localparam int SHIFT   = NBF_INPUT + NBF_COEFF - NBF_OUTPUT;

  localparam logic signed [NB_ACC-1:0] OUT_MAX =
    {{(NB_ACC-NB_OUTPUT+1){1'b0}}, {(NB_OUTPUT-1){1'b1}}};
  localparam logic signed [NB_ACC-1:0] OUT_MIN =
    {{(NB_ACC-NB_OUTPUT+1){1'b1}}, {(NB_OUTPUT-1){1'b0}}};

  logic [NB_PHASE-1:0]         phase_q, phase_d;
  logic signed [NB_INPUT-1:0]  x_q [N_BAUD];
  logic signed [NB_INPUT-1:0]  x_d [N_BAUD];
  logic signed [NB_OUTPUT-1:0] out_q, out_d;

  logic signed [NB_COEFF-1:0]  coeff_k;
  logic signed [NB_ACC-1:0]    acc;
  logic signed [NB_ACC-1:0]    acc_shr;
  logic signed [NB_OUTPUT-1:0] sat_val;

  // Tap k of the current phase uses h[k*N_OS + p]; guard bits keep the sum from wrapping.
  always_comb begin
    acc     = '0;
    coeff_k = '0;
    for (int k = 0; k < N_BAUD; k++) begin
      coeff_k = i_coeff[(k*N_OS + int'(phase_q))*NB_COEFF +: NB_COEFF];
      acc     = acc + NB_ACC'(NB_PROD'(x_q[k]) * NB_PROD'(coeff_k));
    end
  end

  // Arithmetic shift floors toward -inf before clamping to the output range.
  always_comb begin
    acc_shr = acc >>> SHIFT;
    if (acc_shr > OUT_MAX) begin
      sat_val = {1'b0, {(NB_OUTPUT-1){1'b1}}};
    end else if (acc_shr < OUT_MIN) begin
      sat_val = {1'b1, {(NB_OUTPUT-1){1'b0}}};
    end else begin
      sat_val = acc_shr[NB_OUTPUT-1:0];
    end
  end

  always_comb begin
    phase_d = phase_q;
    x_d     = x_q;
    out_d   = out_q;
    if (i_en) begin
      phase_d = phase_q + NB_PHASE'(1);
      out_d   = sat_val;
      if (phase_q == NB_PHASE'(N_OS-1)) begin
        x_d[0] = i_is_data;
        for (int k = 1; k < N_BAUD; k++) begin
          x_d[k] = x_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge i_srst) begin
    if (!i_srst) begin
      phase_q <= '0;
      out_q   <= '0;
      for (int k = 0; k < N_BAUD; k++) begin
        x_q[k] <= '0;
      end
    end else begin
      phase_q <= phase_d;
      out_q   <= out_d;
      for (int k = 0; k < N_BAUD; k++) begin
        x_q[k] <= x_d[k];
      end
    end
  end

  assign o_os_data = out_q;
  assign o_phase   = phase_q;

endmodule

// File: tb/tb_polyphase_fir_interp.sv
// Bench for polyphase_fir_interp: reference model keeps loaded symbols in a queue
// and computes each output as a floored, clamped dot product with plain integers.
module tb_polyphase_fir_interp;

  localparam int N_BAUD = 6;
  localparam int N_OS   = 4;
  localparam int NTAPS  = N_BAUD * N_OS;

  logic              clk;
  logic              i_srst;
  logic              i_en;
  logic [7:0]        i_is_data;
  logic [NTAPS*8-1:0] i_coeff;
  logic [7:0]        o_os_data;
  logic [1:0]        o_phase;

  int checks = 0;
  int errors = 0;

  logic [7:0] h_m [NTAPS];
  int         sym_q [$];
  int         m_phase;
  logic [7:0] m_out;
  logic [7:0] exp_q [$];

  logic [7:0] imp_h [NTAPS];
  logic [7:0] imp_y [NTAPS];

  polyphase_fir_interp #(
    .NB_INPUT(8), .NBF_INPUT(7), .NB_OUTPUT(8), .NBF_OUTPUT(7),
    .NB_COEFF(8), .NBF_COEFF(7), .N_BAUD(N_BAUD), .N_OS(N_OS), .NB_PHASE(2)
  ) dut (
    .clk(clk), .i_srst(i_srst), .i_en(i_en), .i_is_data(i_is_data),
    .i_coeff(i_coeff), .o_os_data(o_os_data), .o_phase(o_phase)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int coef(input int idx);
    return int'($signed(h_m[idx]));
  endfunction

  function automatic logic [7:0] model_out(input int p);
    int sum;
    int r;
    sum = 0;
    for (int k = 0; k < N_BAUD; k++) begin
      if (k < sym_q.size()) sum += sym_q[k] * coef(k*N_OS + p);
    end
    r = sum >>> 7;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r[7:0];
  endfunction

  task automatic set_coeffs();
    for (int i = 0; i < NTAPS; i++) i_coeff[i*8 +: 8] = h_m[i];
  endtask

  task automatic fill_coeffs(input logic [7:0] v);
    for (int i = 0; i < NTAPS; i++) h_m[i] = v;
    set_coeffs();
  endtask

  task automatic model_reset();
    sym_q.delete();
    exp_q.delete();
    m_phase = 0;
    m_out   = 8'h00;
  endtask

  task automatic apply_reset();
    i_srst = 1'b0;
    i_en = 1'b0;
    i_is_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    i_srst = 1'b1;
    model_reset();
  endtask

  // driver: one clock edge, model advances in lockstep, expected output queued
  task automatic drive_cycle(input logic en, input logic [7:0] data);
    logic [7:0] y;
    i_en = en;
    i_is_data = data;
    @(posedge clk);
    if (en) begin
      y = model_out(m_phase);
      if (m_phase == N_OS-1) begin
        sym_q.push_front(int'($signed(data)));
        if (sym_q.size() > N_BAUD) void'(sym_q.pop_back());
      end
      m_phase = (m_phase + 1) % N_OS;
      m_out = y;
    end
    exp_q.push_back(m_out);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    i_srst = 1'b0;
    i_en = 1'b1;
    i_is_data = 8'h7F;
    fill_coeffs(8'h7F);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (o_os_data !== 8'h00 || o_phase !== 2'd0) begin
        errors++;
        $display("FAIL reset_hold: out=%h phase=%0d, want 00/0", o_os_data, o_phase);
      end
    end
    i_srst = 1'b1;
    model_reset();
    fill_coeffs(8'h20);
    for (int i = 0; i < 30; i++) begin
      drive_cycle(1'b1, 8'h40);
      exp = exp_q.pop_front();
      checks++;
      if (o_os_data !== exp || o_phase !== m_phase[1:0]) begin
        errors++;
        $display("FAIL reset_pre_run: out=%h phase=%0d, want %h/%0d", o_os_data, o_phase, exp, m_phase);
      end
    end
    #2;
    i_srst = 1'b0;
    #1;
    checks++;
    if (o_os_data !== 8'h00 || o_phase !== 2'd0) begin
      errors++;
      $display("FAIL reset_async: out=%h phase=%0d, want 00/0", o_os_data, o_phase);
    end
    #2;
    i_srst = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, 8'h40);
      exp = exp_q.pop_front();
      checks++;
      if (o_os_data !== exp || o_phase !== m_phase[1:0]) begin
        errors++;
        $display("FAIL reset_history: out=%h phase=%0d, want %h/%0d", o_os_data, o_phase, exp, m_phase);
      end
    end
  endtask

  task automatic test_impulse();
    logic [7:0] want;
    apply_reset();
    h_m = imp_h;
    set_coeffs();
    for (int n = 1; n <= 32; n++) begin
      drive_cycle(1'b1, (n <= 4) ? 8'h40 : 8'h00);
      want = (n >= 5 && n <= 28) ? imp_y[n-5] : 8'h00;
      void'(exp_q.pop_front());
      checks++;
      if (o_os_data !== want || o_phase !== 2'(n % N_OS)) begin
        errors++;
        $display("FAIL impulse edge %0d: out=%h phase=%0d, want %h/%0d", n, o_os_data, o_phase, want, n % N_OS);
      end
    end
  endtask

  task automatic test_enable();
    int n_en;
    logic en;
    logic [7:0] want;
    apply_reset();
    h_m = imp_h;
    set_coeffs();
    n_en = 0;
    want = 8'h00;
    for (int c = 0; c < 40; c++) begin
      en = !(c >= 11 && c < 16);
      if (en) begin
        n_en++;
        drive_cycle(1'b1, (n_en == 4) ? 8'h40 : 8'h00);
        want = (n_en >= 5 && n_en <= 28) ? imp_y[n_en-5] : 8'h00;
      end else begin
        drive_cycle(1'b0, 8'($urandom_range(1, 255)));
      end
      void'(exp_q.pop_front());
      checks++;
      if (o_os_data !== want || o_phase !== 2'(n_en % N_OS)) begin
        errors++;
        $display("FAIL enable cycle %0d: out=%h phase=%0d, want %h/%0d", c, o_os_data, o_phase, want, n_en % N_OS);
      end
    end
  endtask

  task automatic run_const(input string name, input logic [7:0] h, input logic [7:0] d,
                           input logic [7:0] settle);
    logic [7:0] exp;
    apply_reset();
    fill_coeffs(h);
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1'b1, d);
      exp = exp_q.pop_front();
      checks++;
      if (o_os_data !== exp) begin
        errors++;
        $display("FAIL %s cycle %0d: out=%h want %h", name, i, o_os_data, exp);
      end
    end
    checks++;
    if (o_os_data !== settle) begin
      errors++;
      $display("FAIL %s settle: out=%h want %h", name, o_os_data, settle);
    end
  endtask

  task automatic test_dc_gain();
    run_const("dc_gain", 8'h20, 8'h40, 8'h60);
  endtask

  task automatic test_saturation();
    run_const("sat_pos", 8'h7F, 8'h7F, 8'h7F);
    run_const("sat_neg", 8'h7F, 8'h80, 8'h80);
  endtask

  task automatic test_random();
    logic [7:0] exp;
    apply_reset();
    for (int i = 0; i < NTAPS; i++) h_m[i] = 8'($urandom_range(0, 255));
    set_coeffs();
    for (int c = 0; c < 300; c++) begin
      if (c % 50 == 49) begin
        h_m[$urandom_range(0, NTAPS-1)] = 8'($urandom_range(0, 255));
        set_coeffs();
      end
      drive_cycle($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)));
      exp = exp_q.pop_front();
      checks++;
      if (o_os_data !== exp || o_phase !== m_phase[1:0]) begin
        errors++;
        $display("FAIL random cycle %0d: out=%h phase=%0d, want %h/%0d", c, o_os_data, o_phase, exp, m_phase);
      end
    end
  endtask

  initial begin
    imp_h = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hEC, 8'hFC, 8'hFC,
              8'h00, 8'h50, 8'h13, 8'h1C, 8'h20, 8'h1C, 8'h13, 8'h50,
              8'hFF, 8'hFC, 8'hFC, 8'hEC, 8'h00, 8'h00, 8'h00, 8'h00};
    imp_y = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hF6, 8'hFE, 8'hFE,
              8'h00, 8'h28, 8'h09, 8'h0E, 8'h10, 8'h0E, 8'h09, 8'h28,
              8'hFF, 8'hFE, 8'hFE, 8'hF6, 8'h00, 8'h00, 8'h00, 8'h00};
    i_srst = 1'b0;
    i_en = 1'b0;
    i_is_data = 8'h00;
    i_coeff = '0;
    model_reset();
    #1;
    test_reset();
    test_impulse();
    test_enable();
    test_dc_gain();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
